// File: rtl/ballot_session_ctrl_pkg.sv
// Ballot session shared definitions: session state encodings
// (shared with the election state machine) and default candidate count.
package ballot_session_ctrl_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] ARMED   = 2'b01;
  localparam logic [1:0] LOCKOUT = 2'b10;

  localparam int N_CAND_DEF = 4;

endpackage

// File: rtl/ballot_session_ctrl_timer.sv
// ballot_timer: loadable down-counter used for both the armed timeout
// and the lockout release window. Ports: load/load_val, dec, value, zero.
module ballot_timer #(
  parameter int W = 5
) (
  input  logic         clk_1Hz,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk_1Hz) begin
    if (reset)
      value <= '0;
    else if (load)
      value <= load_val;
    else if (dec && value != '0)
      value <= value - 1'b1;
  end

  assign zero = (value == '0);

endmodule

// File: rtl/ballot_session_ctrl.sv
// ballot_session_ctrl: per-voter ballot sequencer. Arm -> one clean press ->
// vote/spoil/timeout pulse -> lockout until all buttons released.
// Inputs: clk_1Hz, reset, voting_open, btn_arm, btn_cancel, btn_cand.
// Outputs: vote_pulse, spoiled_pulse, timeout_pulse, ballot_armed,
// ballots_cast, spoiled_count, sess_state.
module ballot_session_ctrl
  import ballot_session_ctrl_pkg::*;
#(
  parameter int N_CAND        = N_CAND_DEF,
  parameter int TIMEOUT_TICKS = 30,
  parameter int RELEASE_TICKS = 2,
  parameter int CNT_W         = 9
) (
  input  logic              clk_1Hz,
  input  logic              reset,
  input  logic              voting_open,
  input  logic              btn_arm,
  input  logic              btn_cancel,
  input  logic [N_CAND-1:0] btn_cand,
  output logic [N_CAND-1:0] vote_pulse,
  output logic              spoiled_pulse,
  output logic              timeout_pulse,
  output logic              ballot_armed,
  output logic [CNT_W-1:0]  ballots_cast,
  output logic [CNT_W-1:0]  spoiled_count,
  output logic [1:0]        sess_state
);

  localparam int TMAX = (TIMEOUT_TICKS > RELEASE_TICKS) ?
                        TIMEOUT_TICKS : RELEASE_TICKS;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_ARM = TW'(TIMEOUT_TICKS - 1);
  localparam logic [TW-1:0] T_REL = TW'(RELEASE_TICKS);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  // 0: no button, 1: exactly one, 2: more than one
  function automatic logic [1:0] btn_class(
    input logic [N_CAND-1:0] v
  );
    int cnt;
    cnt = 0;
    for (int i = 0; i < N_CAND; i++)
      cnt += int'(v[i]);
    if (cnt == 0)
      return 2'd0;
    else if (cnt == 1)
      return 2'd1;
    else
      return 2'd2;
  endfunction

  logic [1:0]        st;
  logic [1:0]        st_n;
  logic [N_CAND-1:0] btn_q;
  logic [N_CAND-1:0] press_edge;
  logic [1:0]        bcls;
  logic              any_edge;

  logic              t_load;
  logic [TW-1:0]     t_val;
  logic              t_dec;
  logic [TW-1:0]     t_value;
  logic              t_zero;

  logic [N_CAND-1:0] vote_n;
  logic              spoil_n;
  logic              to_n;

  assign press_edge = btn_cand & ~btn_q;
  assign any_edge   = |press_edge;
  assign bcls       = btn_class(btn_cand);

  ballot_timer #(.W(TW)) u_timer (
    .clk_1Hz  (clk_1Hz),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .value    (t_value),
    .zero     (t_zero)
  );

  always_comb begin
    st_n    = st;
    t_load  = 1'b0;
    t_val   = '0;
    t_dec   = 1'b0;
    vote_n  = '0;
    spoil_n = 1'b0;
    to_n    = 1'b0;
    case (st)
      IDLE: begin
        if (voting_open && btn_arm && bcls == 2'd0) begin
          st_n   = ARMED;
          t_load = 1'b1;
          t_val  = T_ARM;
        end
      end
      ARMED: begin
        if (!voting_open || btn_cancel) begin
          st_n = IDLE;
        end else if (any_edge && bcls == 2'd1) begin
          vote_n = btn_cand;
          st_n   = LOCKOUT;
          t_load = 1'b1;
          t_val  = T_REL;
        end else if (any_edge) begin
          spoil_n = 1'b1;
          st_n    = LOCKOUT;
          t_load  = 1'b1;
          t_val   = T_REL;
        end else if (t_zero) begin
          to_n = 1'b1;
          st_n = IDLE;
        end else begin
          t_dec = 1'b1;
        end
      end
      LOCKOUT: begin
        if (bcls != 2'd0) begin
          t_load = 1'b1;
          t_val  = T_REL;
        end else begin
          t_dec = 1'b1;
          // this decrement ends the release window
          if (t_value <= T_ONE)
            st_n = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      st            <= IDLE;
      btn_q         <= '0;
      vote_pulse    <= '0;
      spoiled_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
      ballots_cast  <= '0;
      spoiled_count <= '0;
    end else begin
      st            <= st_n;
      btn_q         <= btn_cand;
      vote_pulse    <= vote_n;
      spoiled_pulse <= spoil_n;
      timeout_pulse <= to_n;
      if (|vote_n && ballots_cast != C_MAX)
        ballots_cast <= ballots_cast + 1'b1;
      if (spoil_n && spoiled_count != C_MAX)
        spoiled_count <= spoiled_count + 1'b1;
    end
  end

  assign ballot_armed = (st == ARMED);
  assign sess_state   = st;

endmodule
